// File: rtl/demux_route_ctrl.sv
// ============================================================================
// Module   : demux_route_ctrl
// Brief    : Valid/ready 1-to-2 router (select or round-robin steering) with
//            one-entry holding register and delivery counter per channel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_route_ctrl #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic             rr_ptr
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_t;

  localparam int c_NUM_CH = 2;

  logic                w_tgt;
  logic                w_accept;
  logic [c_NUM_CH-1:0] w_rdy;
  logic [c_NUM_CH-1:0] w_full;
  logic                r_rr_ptr;

  assign w_tgt    = mode ? r_rr_ptr : in_sel;
  assign w_rdy    = {out1_ready, out0_ready};
  // A full target can still take a word when it drains in the same cycle.
  assign in_ready = ~w_full[w_tgt] | w_rdy[w_tgt];
  assign w_accept = in_valid & in_ready;

  generate
    for (genvar gi = 0; gi < c_NUM_CH; gi++) begin : g_ch
      ch_state_t        r_state;
      logic [WIDTH-1:0] r_data;
      logic [CNT_W-1:0] r_cnt;
      logic             w_drain;
      logic             w_acc;

      assign w_full[gi] = (r_state == FULL);
      assign w_drain    = w_full[gi] & w_rdy[gi];
      assign w_acc      = w_accept & (w_tgt == 1'(gi));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_state <= EMPTY;
          r_data  <= '0;
          r_cnt   <= '0;
        end else begin
          case (r_state)
            EMPTY:   if (w_acc) r_state <= FULL;
            FULL:    if (w_drain && !w_acc) r_state <= EMPTY;
            default: r_state <= EMPTY;
          endcase
          if (w_acc) r_data <= in_data;
          if (w_drain) r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rr_ptr <= 1'b0;
    else if (w_accept && mode) r_rr_ptr <= ~r_rr_ptr;
  end

  assign out0_valid = w_full[0];
  assign out1_valid = w_full[1];
  assign out0_data  = g_ch[0].r_data;
  assign out1_data  = g_ch[1].r_data;
  assign cnt0       = g_ch[0].r_cnt;
  assign cnt1       = g_ch[1].r_cnt;
  assign rr_ptr     = r_rr_ptr;

endmodule

`default_nettype wire

// File: tb/tb_demux_route_ctrl.sv
// ============================================================================
// Module   : tb_demux_route_ctrl
// Brief    : Directed self-checking bench for demux_route_ctrl (WIDTH=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux_route_ctrl;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic             in_sel;
  logic [WIDTH-1:0] in_data;
  logic             out0_valid, out1_valid;
  logic             out0_ready, out1_ready;
  logic [WIDTH-1:0] out0_data, out1_data;
  logic [CNT_W-1:0] cnt0, cnt1;
  logic             rr_ptr;

  int pass_cnt = 0;
  int total    = 0;

  demux_route_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .cnt0       (cnt0),
    .cnt1       (cnt1),
    .rr_ptr     (rr_ptr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] rr_ch;
    rr_ch = 4'b0000;
    rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    out0_ready = 1'b1; out1_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    #1;
    chk("rst_v0",   32'(out0_valid), 32'd0);
    chk("rst_v1",   32'(out1_valid), 32'd0);
    chk("rst_d0",   32'(out0_data),  32'd0);
    chk("rst_d1",   32'(out1_data),  32'd0);
    chk("rst_cnt0", 32'(cnt0),       32'd0);
    chk("rst_cnt1", 32'(cnt1),       32'd0);
    chk("rst_rr",   32'(rr_ptr),     32'd0);
    chk("rst_rdy",  32'(in_ready),   32'd1);

    // Mode 0 routing: 0xA to ch0 then 0x5 to ch1 on consecutive cycles
    step();
    in_valid = 1'b1; in_sel = 1'b0; in_data = 4'hA;
    #1 chk("m0_rdy_a", 32'(in_ready), 32'd1);
    step();
    chk("m0_v0", 32'(out0_valid), 32'd1);
    chk("m0_d0", 32'(out0_data),  32'hA);
    in_sel = 1'b1; in_data = 4'h5;
    step();
    chk("m0_v1",      32'(out1_valid), 32'd1);
    chk("m0_d1",      32'(out1_data),  32'h5);
    chk("m0_v0_done", 32'(out0_valid), 32'd0);
    in_valid = 1'b0;
    step();
    chk("m0_cnt0", 32'(cnt0), 32'd1);
    chk("m0_cnt1", 32'(cnt1), 32'd1);
    chk("m0_v1_done", 32'(out1_valid), 32'd0);

    // Idle ch0 keeps its last value; out_ready on an empty channel does nothing
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_v0", 32'(out0_valid), 32'd0);
      chk("hold_d0", 32'(out0_data),  32'hA);
    end
    chk("hold_cnt0", 32'(cnt0), 32'd1);

    // Backpressure on ch0
    out0_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 4'h3;
    step();
    chk("bp_d0", 32'(out0_data), 32'h3);
    in_data = 4'h7;
    #1 chk("bp_rdy_blocked", 32'(in_ready), 32'd0);
    step();
    chk("bp_d0_held", 32'(out0_data), 32'h3);
    in_sel = 1'b1; in_data = 4'h9;
    #1 chk("bp_rdy_ch1", 32'(in_ready), 32'd1);
    step();
    chk("bp_v1", 32'(out1_valid), 32'd1);
    chk("bp_d1", 32'(out1_data),  32'h9);
    in_sel = 1'b0; in_data = 4'h7;
    #1 chk("bp_rdy_again", 32'(in_ready), 32'd0);
    out0_ready = 1'b1;
    #1 chk("bp_rdy_release", 32'(in_ready), 32'd1);
    step();
    chk("bp_refill_v0", 32'(out0_valid), 32'd1);
    chk("bp_refill_d0", 32'(out0_data),  32'h7);
    chk("bp_cnt0",      32'(cnt0),       32'd2);
    chk("bp_cnt1",      32'(cnt1),       32'd2);
    in_valid = 1'b0;
    step();
    chk("bp_cnt0_final", 32'(cnt0), 32'd3);

    // Round-robin: words 0..5 alternate ch0, ch1 starting at ch0
    mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 4'(i);
      #1 chk("rr_rdy", 32'(in_ready), 32'd1);
      step();
      if (i % 2 == 0) begin
        chk("rr_v0", 32'(out0_valid), 32'd1);
        chk("rr_d0", 32'(out0_data),  32'(i));
      end else begin
        chk("rr_v1", 32'(out1_valid), 32'd1);
        chk("rr_d1", 32'(out1_data),  32'(i));
      end
      rr_ch[0] = ~rr_ch[0];
    end
    chk("rr_ptr_end", 32'(rr_ptr), 32'd0);
    in_valid = 1'b0;
    step();
    chk("rr_cnt0", 32'(cnt0), 32'd6);
    chk("rr_cnt1", 32'(cnt1), 32'd5);

    // One more rr word, then switching to mode 0 keeps rr_ptr
    in_valid = 1'b1; in_data = 4'hE;
    step();
    chk("rr_one_d0", 32'(out0_data), 32'hE);
    in_valid = 1'b0; mode = 1'b0;
    step();
    chk("mode_sw_rr", 32'(rr_ptr), 32'd1);
    step();
    chk("mode_sw_rr2", 32'(rr_ptr), 32'd1);

    // Mid-cycle async reset with both channels full
    out0_ready = 1'b0; out1_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 4'hC;
    step();
    in_sel = 1'b1; in_data = 4'hD;
    step();
    in_valid = 1'b0;
    chk("pre_rst_v0", 32'(out0_valid), 32'd1);
    chk("pre_rst_v1", 32'(out1_valid), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("arst_v0",   32'(out0_valid), 32'd0);
    chk("arst_v1",   32'(out1_valid), 32'd0);
    chk("arst_d0",   32'(out0_data),  32'd0);
    chk("arst_d1",   32'(out1_data),  32'd0);
    chk("arst_cnt0", 32'(cnt0),       32'd0);
    chk("arst_cnt1", 32'(cnt1),       32'd0);
    chk("arst_rr",   32'(rr_ptr),     32'd0);
    chk("arst_rdy",  32'(in_ready),   32'd1);
    step();
    rst = 1'b0;
    mode = 1'b1; in_valid = 1'b1; in_data = 4'h1;
    step();
    chk("post_rst_v0", 32'(out0_valid), 32'd1);
    chk("post_rst_d0", 32'(out0_data),  32'h1);
    chk("post_rst_v1", 32'(out1_valid), 32'd0);
    chk("post_rst_rr", 32'(rr_ptr),     32'd1);
    in_valid = 1'b0; out0_ready = 1'b1; out1_ready = 1'b1;
    step();
    chk("post_rst_cnt0", 32'(cnt0), 32'd1);

    // Counter wrap: 256 streamed drains on ch1
    mode = 1'b0; in_sel = 1'b1; in_valid = 1'b1;
    for (int s = 1; s <= 256; s++) begin
      in_data = 4'(s);
      step();
    end
    chk("wrap_cnt1_255", 32'(cnt1), 32'd255);
    in_valid = 1'b0;
    step();
    chk("wrap_cnt1_0",   32'(cnt1), 32'd0);
    chk("wrap_cnt0",     32'(cnt0), 32'd1);
    chk("wrap_v1",       32'(out1_valid), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/demux_route_ctrl.md
# demux_route_ctrl

Sequencing controller for the 1-to-2 routing datapath. It accepts a single valid/ready input stream and steers each word to one of two output channels. Steering is either by an explicit select bit or by round-robin. Each channel has a one-entry holding register, so the last routed value stays on an idle output instead of being inferred as a latch. Per-channel delivery counters support debug and verification.

## Interface
- WIDTH, 1, data width of input and both outputs
- CNT_W, 8, width of each per-channel delivery counter

- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- mode  input  1  0 = routing by in_sel; 1 = round-robin routing
- in_valid  input  1  input word present
- in_ready  output  1  input word accepted this cycle when in_valid & in_ready
- in_sel  input  1  target channel when mode=0 (0 → ch0, 1 → ch1); ignored when mode=1
- in_data  input  WIDTH  input word
- out0_valid / out1_valid  output  1  channel holding register full
- out0_ready / out1_ready  input  1  downstream accepts word
- out0_data / out1_data  output  WIDTH  channel holding register contents
- cnt0 / cnt1  output  CNT_W  count of completed output handshakes per channel
- rr_ptr  output  1  next round-robin target (status only)

## Operation
- Target channel T: T = in_sel when mode=0; T = rr_ptr when mode=1. T is evaluated combinationally in the current cycle.
- Per-channel FSM has two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Channel transitions:
  - EMPTY → FULL on an accept targeting that channel.
  - FULL → EMPTY on drain (out_valid & out_ready) with no accept into that channel.
  - FULL → FULL on simultaneous drain and accept (refill in the same cycle).
- in_ready = (T channel EMPTY) | (T channel out_ready). This is a combinational path from out_ready and in_sel to in_ready; it is intentional.
- On accept, in_data is written into the T channel data register. The other channel is not affected.
- out_data is written only on accept. After a drain it holds its last value while out_valid=0.
- rr_ptr:
  - Toggles on every accept while mode=1.
  - Holds while mode=0.
  - Switching mode does not modify it.
- cntN increments by 1 on each channel-N drain and wraps from 2^CNT_W−1 to 0. It never saturates.
- Words are never dropped or duplicated. Each accepted word produces exactly one output handshake.
- Ordering is FIFO per channel (depth 1). No ordering is guaranteed across channels.

## Timing
- Reset (asynchronous, immediate):
  - out0_valid = out1_valid = 0
  - out0_data = out1_data = 0
  - cnt0 = cnt1 = 0
  - rr_ptr = 0
  - in_ready evaluates to 1 (both channels EMPTY)
- Latency: a word accepted at edge k appears with out_valid=1 in the cycle after edge k (one cycle).
- Throughput is one word per cycle, sustained on a single channel when its out_ready is held at 1, and sustained when alternating channels.
- Backpressure: when T is FULL and its out_ready=0, in_ready=0. The input must then hold in_valid, in_data and in_sel stable until accepted. The other channel continues to drain independently.
- Reset asserted mid-transfer: held words are discarded and counters clear. The first accept after rst deasserts goes to ch0 in mode=1.
- An out_ready asserted while out_valid=0 has no effect: no count, no state change.

## Test plan
- Reset then idle: assert rst mid-cycle with both channels FULL → all outputs are zero immediately and in_ready=1. After release, with mode=1, send 0x1 → it lands on ch0.
- Mode 0 routing (WIDTH=4): send 0xA with sel=0 and 0x5 with sel=1 on consecutive cycles, both out_ready=1 → out0_data=0xA one cycle after accept and out1_data=0x5 the next cycle; cnt0=cnt1=1.
- Hold value: after ch0 drains 0xA with no further traffic → out0_valid=0 and out0_data stays 0xA for 10 cycles.
- Backpressure: out0_ready=0 with ch0 FULL, then send sel=0 → in_ready=0. Send sel=1 → accepted on ch1. Release out0_ready → the pending sel=0 word is accepted in the same cycle ch0 drains, and ch0 stays FULL.
- Round-robin: mode=1 with 6 back-to-back words 0..5 and both readies high → ch0 gets 0,2,4 and ch1 gets 1,3,5; rr_ptr ends at 0.
- Counter wrap (CNT_W=8): 256 drains on ch1 → cnt1 goes 255 → 0 and cnt0 is unchanged.
